// File: rtl/iq_deserializer.sv
// Reassembles 24-bit-aligned IQ samples from a sync-framed byte stream (4 bytes/sample).
// Outputs register 1 cycle after im_hi; no backpressure. `IQ_DESER_FRAME_CHECK_EN enforces sync on every frame.
module iq_deserializer #(
  parameter int OUT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             sync,
  output logic [OUT_W-1:0] out_re,
  output logic [OUT_W-1:0] out_im,
  output logic             out_valid,
  output logic             sync_err
);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       re_lo_q, re_lo_d;
  logic [7:0]       re_hi_q, re_hi_d;
  logic [7:0]       im_lo_q, im_lo_d;
  logic [OUT_W-1:0] out_re_q, out_re_d;
  logic [OUT_W-1:0] out_im_q, out_im_d;
  logic             out_valid_q, out_valid_d;
  logic             sync_err_q, sync_err_d;
  logic [1:0]       rst_sync_q;
  logic             run;

  // Assertion is immediate; release is delayed two edges so it never races the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run = rst_sync_q[1];

  function automatic logic [OUT_W-1:0] pack_word(input logic [7:0] hi, input logic [7:0] lo);
    logic [OUT_W-1:0] w;
    w = '0;
    w[OUT_W-1 -: 16] = {hi, lo};
    return w;
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    re_lo_d     = re_lo_q;
    re_hi_d     = re_hi_q;
    im_lo_d     = im_lo_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_valid_d = 1'b0;
    sync_err_d  = 1'b0;

    if (!run) begin
      state_d  = HUNT;
      idx_d    = 2'd0;
      re_lo_d  = 8'h00;
      re_hi_d  = 8'h00;
      im_lo_d  = 8'h00;
      out_re_d = '0;
      out_im_d = '0;
    end else if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (sync) begin
            re_lo_d = in_data;
            idx_d   = 2'd1;
            state_d = LOCK;
          end
        end
        LOCK: begin
          if (sync && (idx_q != 2'd0)) begin
            // Resynchronise onto the new frame; the partial one is dropped.
            sync_err_d = 1'b1;
            re_lo_d    = in_data;
            idx_d      = 2'd1;
`ifdef IQ_DESER_FRAME_CHECK_EN
          end else if (!sync && (idx_q == 2'd0)) begin
            sync_err_d = 1'b1;
            state_d    = HUNT;
`endif
          end else begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
              2'd0: re_lo_d = in_data;
              2'd1: re_hi_d = in_data;
              2'd2: im_lo_d = in_data;
              default: begin
                out_re_d    = pack_word(re_hi_q, re_lo_q);
                out_im_d    = pack_word(in_data, im_lo_q);
                out_valid_d = 1'b1;
              end
            endcase
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      idx_q       <= 2'd0;
      re_lo_q     <= 8'h00;
      re_hi_q     <= 8'h00;
      im_lo_q     <= 8'h00;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      re_lo_q     <= re_lo_d;
      re_hi_q     <= re_hi_d;
      im_lo_q     <= im_lo_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_valid = out_valid_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_iq_deserializer.sv
// Bench for iq_deserializer: directed frames from the test plan plus random byte streams
// checked cycle by cycle against a queue-based frame model.
module tb_iq_deserializer;
  localparam int OUT_W = 24;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_valid = 1'b0;
  logic             sync = 1'b0;
  logic [OUT_W-1:0] out_re;
  logic [OUT_W-1:0] out_im;
  logic             out_valid;
  logic             sync_err;

  int chk_cnt = 0;
  int pass_cnt = 0;

  // Reference model: bytes of the frame in progress, plus whether we are aligned.
  logic [7:0]       fq[$];
  bit               locked = 1'b0;
  logic [OUT_W-1:0] exp_re = '0;
  logic [OUT_W-1:0] exp_im = '0;
  logic             exp_vld = 1'b0;
  logic             exp_err = 1'b0;

  iq_deserializer #(.OUT_W(OUT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .sync     (sync),
    .out_re   (out_re),
    .out_im   (out_im),
    .out_valid(out_valid),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  // Called at posedge+1; drives one cycle, predicts outputs, returns at the next posedge+1.
  task automatic drive_cycle(input logic v, input logic s, input logic [7:0] d);
    in_valid = v;
    sync     = s;
    in_data  = d;
    exp_vld  = 1'b0;
    exp_err  = 1'b0;
    if (v) begin
      if (!locked) begin
        if (s) begin
          fq = {d};
          locked = 1'b1;
        end
      end else if (s) begin
        if (fq.size() != 0) exp_err = 1'b1;
        fq = {d};
      end else if (fq.size() == 0) begin
`ifdef IQ_DESER_FRAME_CHECK_EN
        exp_err = 1'b1;
        locked  = 1'b0;
`else
        fq.push_back(d);
`endif
      end else begin
        fq.push_back(d);
      end
      if (fq.size() == 4) begin
        exp_re  = {fq[1], fq[0], 8'h00};
        exp_im  = {fq[3], fq[2], 8'h00};
        exp_vld = 1'b1;
        fq.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Entry encoding {valid, sync, data}; idle entries carry random ignored sync/data.
  task automatic drive_entry(input logic [9:0] e);
    if (e[9]) drive_cycle(1'b1, e[8], e[7:0]);
    else drive_cycle(1'b0, 1'($urandom), 8'($urandom));
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sync     = 1'b0;
    fq.delete();
    locked   = 1'b0;
    exp_re   = '0;
    exp_im   = '0;
    exp_vld  = 1'b0;
    exp_err  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) drive_cycle(1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    chk_cnt++;
    if (out_re !== '0) $display("FAIL reset_re: got %h want 0", out_re); else pass_cnt++;
    chk_cnt++;
    if (out_im !== '0) $display("FAIL reset_im: got %h want 0", out_im); else pass_cnt++;
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_vld: got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++;
    if (sync_err !== 1'b0) $display("FAIL reset_err: got %b want 0", sync_err); else pass_cnt++;
    do_reset();
    chk_cnt++;
    if ({out_valid, sync_err, out_re, out_im} !== '0)
      $display("FAIL post_reset: got %b/%b/%h/%h want all zero", out_valid, sync_err, out_re, out_im);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [9:0] t[6];
    int ov = 0, er = 0;
    t = '{10'h334, 10'h212, 10'h278, 10'h256, 10'h000, 10'h000};
    do_reset();
    foreach (t[i]) begin
      drive_entry(t[i]);
      ov += int'(out_valid);
      er += int'(sync_err);
      chk_cnt++;
      if ({out_valid, sync_err, out_re, out_im} !== {exp_vld, exp_err, exp_re, exp_im})
        $display("FAIL basic step%0d: got %b/%b/%h/%h want %b/%b/%h/%h", i,
                 out_valid, sync_err, out_re, out_im, exp_vld, exp_err, exp_re, exp_im);
      else pass_cnt++;
    end
    chk_cnt++;
    if (out_re !== 24'h123400) $display("FAIL basic_re: got %h want 123400", out_re); else pass_cnt++;
    chk_cnt++;
    if (out_im !== 24'h567800) $display("FAIL basic_im: got %h want 567800", out_im); else pass_cnt++;
    chk_cnt++;
    if (ov != 1 || er != 0) $display("FAIL basic_pulses: got vld=%0d err=%0d want 1 0", ov, er); else pass_cnt++;
  endtask

  task automatic test_hunt_discard();
    logic [9:0] t[7];
    int ov = 0, er = 0;
    t = '{10'h2AA, 10'h2BB, 10'h334, 10'h212, 10'h278, 10'h256, 10'h000};
    do_reset();
    foreach (t[i]) begin
      drive_entry(t[i]);
      ov += int'(out_valid);
      er += int'(sync_err);
      chk_cnt++;
      if ({out_valid, sync_err, out_re, out_im} !== {exp_vld, exp_err, exp_re, exp_im})
        $display("FAIL hunt step%0d: got %b/%b/%h/%h want %b/%b/%h/%h", i,
                 out_valid, sync_err, out_re, out_im, exp_vld, exp_err, exp_re, exp_im);
      else pass_cnt++;
    end
    chk_cnt++;
    if (out_re !== 24'h123400 || out_im !== 24'h567800 || ov != 1 || er != 0)
      $display("FAIL hunt_result: got re=%h im=%h vld=%0d err=%0d want 123400 567800 1 0", out_re, out_im, ov, er);
    else pass_cnt++;
  endtask

  task automatic test_gaps();
    logic [9:0] t[9];
    int ov = 0, er = 0, ov_at = -1;
    t = '{10'h300, 10'h280, 10'h000, 10'h000, 10'h000, 10'h2FF, 10'h000, 10'h27F, 10'h000};
    foreach (t[i]) begin
      drive_entry(t[i]);
      if (out_valid === 1'b1) ov_at = i;
      ov += int'(out_valid);
      er += int'(sync_err);
      chk_cnt++;
      if ({out_valid, sync_err, out_re, out_im} !== {exp_vld, exp_err, exp_re, exp_im})
        $display("FAIL gaps step%0d: got %b/%b/%h/%h want %b/%b/%h/%h", i,
                 out_valid, sync_err, out_re, out_im, exp_vld, exp_err, exp_re, exp_im);
      else pass_cnt++;
    end
    chk_cnt++;
    if (out_re !== 24'h800000 || out_im !== 24'h7FFF00)
      $display("FAIL gaps_words: got %h %h want 800000 7fff00", out_re, out_im);
    else pass_cnt++;
    chk_cnt++;
    if (ov != 1 || er != 0 || ov_at != 7)
      $display("FAIL gaps_pulse: got vld=%0d err=%0d at=%0d want 1 0 7", ov, er, ov_at);
    else pass_cnt++;
  endtask

  task automatic test_mid_sync();
    logic [9:0] t[7];
    int ov = 0, er = 0, er_at = -1;
    t = '{10'h311, 10'h222, 10'h334, 10'h212, 10'h278, 10'h256, 10'h000};
    foreach (t[i]) begin
      drive_entry(t[i]);
      if (sync_err === 1'b1) er_at = i;
      ov += int'(out_valid);
      er += int'(sync_err);
      chk_cnt++;
      if ({out_valid, sync_err, out_re, out_im} !== {exp_vld, exp_err, exp_re, exp_im})
        $display("FAIL midsync step%0d: got %b/%b/%h/%h want %b/%b/%h/%h", i,
                 out_valid, sync_err, out_re, out_im, exp_vld, exp_err, exp_re, exp_im);
      else pass_cnt++;
    end
    chk_cnt++;
    if (ov != 1 || er != 1 || er_at != 2 || out_re !== 24'h123400 || out_im !== 24'h567800)
      $display("FAIL midsync_result: got vld=%0d err=%0d at=%0d re=%h im=%h want 1 1 2 123400 567800",
               ov, er, er_at, out_re, out_im);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [9:0] t[9];
    int ov = 0, er = 0;
    t = '{10'h334, 10'h212, 10'h278, 10'h256, 10'h29A, 10'h2BC, 10'h2DE, 10'h2F0, 10'h000};
    do_reset();
    foreach (t[i]) begin
      drive_entry(t[i]);
      ov += int'(out_valid);
      er += int'(sync_err);
      chk_cnt++;
      if ({out_valid, sync_err, out_re, out_im} !== {exp_vld, exp_err, exp_re, exp_im})
        $display("FAIL b2b step%0d: got %b/%b/%h/%h want %b/%b/%h/%h", i,
                 out_valid, sync_err, out_re, out_im, exp_vld, exp_err, exp_re, exp_im);
      else pass_cnt++;
    end
`ifdef IQ_DESER_FRAME_CHECK_EN
    chk_cnt++;
    if (ov != 1 || er != 1 || out_re !== 24'h123400 || out_im !== 24'h567800)
      $display("FAIL b2b_result: got vld=%0d err=%0d re=%h im=%h want 1 1 123400 567800", ov, er, out_re, out_im);
    else pass_cnt++;
    // Back in HUNT, unsynced bytes must vanish silently.
    t = '{10'h211, 10'h222, 10'h233, 10'h244, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000};
    foreach (t[i]) begin
      drive_entry(t[i]);
      ov += int'(out_valid);
      er += int'(sync_err);
    end
    chk_cnt++;
    if (ov != 1 || er != 1)
      $display("FAIL b2b_hunt: got vld=%0d err=%0d want 1 1", ov, er);
    else pass_cnt++;
`else
    chk_cnt++;
    if (ov != 2 || er != 0 || out_re !== 24'hBC9A00 || out_im !== 24'hF0DE00)
      $display("FAIL b2b_result: got vld=%0d err=%0d re=%h im=%h want 2 0 bc9a00 f0de00", ov, er, out_re, out_im);
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] t[9];
    int ov = 0;
    do_reset();
    drive_entry(10'h334);
    drive_entry(10'h212);
    drive_entry(10'h278);
    drive_entry(10'h256);
    drive_entry(10'h3EE);
    drive_entry(10'h2DD);
    rst_n = 1'b0;
    #2;
    chk_cnt++;
    if ({out_valid, sync_err, out_re, out_im} !== '0)
      $display("FAIL rstmid_during: got %b/%b/%h/%h want all zero", out_valid, sync_err, out_re, out_im);
    else pass_cnt++;
    do_reset();
    t = '{10'h2CC, 10'h2BB, 10'h000, 10'h3AB, 10'h2CD, 10'h2EF, 10'h201, 10'h000, 10'h000};
    foreach (t[i]) begin
      drive_entry(t[i]);
      ov += int'(out_valid);
      chk_cnt++;
      if ({out_valid, sync_err, out_re, out_im} !== {exp_vld, exp_err, exp_re, exp_im})
        $display("FAIL rstmid step%0d: got %b/%b/%h/%h want %b/%b/%h/%h", i,
                 out_valid, sync_err, out_re, out_im, exp_vld, exp_err, exp_re, exp_im);
      else pass_cnt++;
    end
    chk_cnt++;
    if (ov != 1 || out_re !== 24'hCDAB00 || out_im !== 24'h01EF00)
      $display("FAIL rstmid_result: got vld=%0d re=%h im=%h want 1 cdab00 01ef00", ov, out_re, out_im);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic v, s;
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(3) != 0);
      s = ($urandom_range(5) == 0);
      d = 8'($urandom);
      drive_cycle(v, s, d);
      chk_cnt++;
      if ({out_valid, sync_err, out_re, out_im} !== {exp_vld, exp_err, exp_re, exp_im})
        $display("FAIL random cyc%0d: got %b/%b/%h/%h want %b/%b/%h/%h", i,
                 out_valid, sync_err, out_re, out_im, exp_vld, exp_err, exp_re, exp_im);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hunt_discard();
    test_gaps();
    test_mid_sync();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
